// File: rtl/int_fp_div_pkg.sv
// int_fp_div_pkg: fp16/int8 format constants, step counts and FSM states for int_fp_div
package int_fp_div_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam logic signed [6:0] BIAS = 7'sd15;
  localparam logic [4:0] EXP_INF = 5'h1F;
  localparam logic [3:0] INT_STEPS = 4'd8;
  localparam logic [3:0] FP_STEPS = 4'd12;
  localparam logic [7:0] INT8_MAX = 8'h7F;
  localparam logic [7:0] INT8_MIN = 8'h80;
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
endpackage

// File: rtl/int_fp_div_step.sv
// div_restore_step: one radix-2 restoring division step (shift in a bit, trial subtract)
module div_restore_step (
  input  logic [10:0] rem,
  input  logic        bit_in,
  input  logic [10:0] dvs,
  output logic [10:0] rem_next,
  output logic        q
);
  logic [11:0] t, d;
  assign t = {rem, bit_in};
  assign d = t - {1'b0, dvs};
  assign q = t >= {1'b0, dvs};
  assign rem_next = q ? d[10:0] : t[10:0];
endmodule

// File: rtl/int_fp_div.sv
// int_fp_div: iterative restoring divider for int8 and fp16 operands, one quotient bit per clock.
// ROUND_NEAREST_EN adds a guard step and round-to-nearest-even for fp; otherwise fp truncates.
module int_fp_div
  import int_fp_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        error
);
`ifdef ROUND_NEAREST_EN
  localparam logic [3:0] FP_RUN = FP_STEPS + 4'd1;
`else
  localparam logic [3:0] FP_RUN = FP_STEPS;
`endif
  localparam int QW = int'(FP_RUN);
  state_t state;
  logic [3:0] cnt;
  logic md, sq, sr, ovf;
  logic [10:0] rem, dvs, rem_n;
  logic [7:0] dvd;
  logic [QW-1:0] quo;
  logic signed [6:0] exp_d, e0, e;
  logic qb;
  logic [4:0] ea, eb;
  logic [7:0] mag_a, mag_b, qv, rv;
  logic az, bz, s_fp, spec, spec_e, hi, fp_e;
  logic [15:0] spec_c, fp_c;
  logic [11:0] q12;
  logic [9:0] mant0, mant;
`ifdef ROUND_NEAREST_EN
  logic up, co;
`endif
  div_restore_step u_step (.rem(rem), .bit_in(dvd[7]), .dvs(dvs), .rem_next(rem_n), .q(qb));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign ea = a[MAN_W+EXP_W-1:MAN_W];
  assign eb = b[MAN_W+EXP_W-1:MAN_W];
  assign az = ea == '0;
  assign bz = eb == '0;
  assign s_fp = a[15] ^ b[15];
  assign mag_a = a[7] ? -a[7:0] : a[7:0];
  assign mag_b = b[7] ? -b[7:0] : b[7:0];
  // A zero divisor wins over a zero dividend in fp mode
  assign spec = mode ? (az | bz) : (b[7:0] == '0);
  assign spec_e = mode ? bz : 1'b1;
  assign spec_c = mode ? (bz ? {s_fp, EXP_INF, {MAN_W{1'b0}}} : {s_fp, 15'h0})
                       : {8'h00, a[7] ? INT8_MIN : INT8_MAX};
  always_comb begin
    q12 = quo[QW-1:QW-12];
    hi = q12[11];
    mant0 = hi ? q12[10:1] : q12[9:0];
    e0 = exp_d + (hi ? BIAS : BIAS - 7'sd1);
`ifdef ROUND_NEAREST_EN
    up = (hi ? q12[0] : quo[0]) & ((hi & quo[0]) | (rem != '0) | mant0[0]);
    {co, mant} = {1'b0, mant0} + {10'b0, up};
    e = e0 + $signed({6'b0, co});
`else
    mant = mant0;
    e = e0;
`endif
    fp_e = (e >= 7'sd31) | (e <= 7'sd0);
    fp_c = e >= 7'sd31 ? {sq, EXP_INF, {MAN_W{1'b0}}} : e <= 7'sd0 ? {sq, 15'h0} : {sq, e[4:0], mant};
    qv = sq ? -quo[7:0] : quo[7:0];
    rv = sr ? -rem[7:0] : rem[7:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      md <= 1'b0;
      sq <= 1'b0;
      sr <= 1'b0;
      ovf <= 1'b0;
      rem <= '0;
      dvs <= '0;
      dvd <= '0;
      quo <= '0;
      exp_d <= '0;
      c <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          md <= mode;
          sq <= mode ? s_fp : a[7] ^ b[7];
          sr <= a[7];
          ovf <= !mode && a[7:0] == INT8_MIN && b[7:0] == 8'hFF;
          // fp starts with ma>>1 as partial remainder so the quotient equals (ma<<11)/mb
          rem <= mode ? {2'b01, a[MAN_W-1:1]} : '0;
          dvs <= mode ? {1'b1, b[MAN_W-1:0]} : {3'b0, mag_b};
          dvd <= mode ? {a[0], 7'b0} : mag_a;
          quo <= '0;
          exp_d <= $signed({2'b0, ea}) - $signed({2'b0, eb});
          cnt <= mode ? FP_RUN : INT_STEPS;
          state <= spec ? DONE : DIV;
          if (spec) begin
            c <= spec_c;
            error <= spec_e;
          end
        end
        DIV: begin
          rem <= rem_n;
          dvd <= {dvd[6:0], 1'b0};
          quo <= {quo[QW-2:0], qb};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= NORM;
        end
        NORM: begin
          c <= md ? fp_c : (ovf ? {8'h00, INT8_MAX} : {rv, qv});
          error <= md ? fp_e : ovf;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_int_fp_div.sv
// tb_int_fp_div: scoreboard bench for int_fp_div with directed vectors and a random reference-model sweep
module tb_int_fp_div;
`ifdef ROUND_NEAREST_EN
  localparam int LAT_FP = 14;
`else
  localparam int LAT_FP = 13;
`endif
  typedef struct {
    logic [15:0] c;
    logic        e;
    int          lat;
  } exp_t;
  logic clk = 1'b0, rst, in_valid, in_ready, mode, out_valid, out_ready, error;
  logic [15:0] a, b, c;
  logic hold = 1'b0;
  int cyc = 0, checks = 0, passed = 0;
  exp_t sb_q[$];
  int acc_q[$];
  int_fp_div dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
                  .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .error(error));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask
  function automatic exp_t mk(input logic [15:0] cv, input logic ev, input int lat);
    exp_t r;
    r.c = cv;
    r.e = ev;
    r.lat = lat;
    return r;
  endfunction
  // Reference model: exact integer arithmetic on the decoded operand values
  function automatic exp_t model(input logic m, input logic [15:0] x, input logic [15:0] y);
    int sa, sb, q, rm, ea, eb, k, e;
    longint ma, mb, num, mq, rr;
    logic s;
    if (!m) begin
      sa = $signed(x[7:0]);
      sb = $signed(y[7:0]);
      if (sb == 0) return mk({8'h00, sa < 0 ? 8'h80 : 8'h7F}, 1'b1, 0);
      if (sa == -128 && sb == -1) return mk(16'h007F, 1'b1, 9);
      q = sa / sb;
      rm = sa % sb;
      return mk({rm[7:0], q[7:0]}, 1'b0, 9);
    end
    s = x[15] ^ y[15];
    ea = int'(x[14:10]);
    eb = int'(y[14:10]);
    if (eb == 0) return mk({s, 5'h1F, 10'h0}, 1'b1, 0);
    if (ea == 0) return mk({s, 15'h0}, 1'b0, 0);
    ma = 1024 + longint'(x[9:0]);
    mb = 1024 + longint'(y[9:0]);
    k = ma >= mb ? 10 : 11;
    e = ea - eb + 15 - (k - 10);
    num = ma << k;
    mq = num / mb;
    rr = num % mb;
`ifdef ROUND_NEAREST_EN
    if (2 * rr > mb || (2 * rr == mb && mq[0])) mq++;
    if (mq == 2048) begin
      mq = 1024;
      e++;
    end
`endif
    if (e >= 31) return mk({s, 5'h1F, 10'h0}, 1'b1, LAT_FP);
    if (e <= 0) return mk({s, 15'h0}, 1'b1, LAT_FP);
    return mk({s, e[4:0], mq[9:0]}, 1'b0, LAT_FP);
  endfunction
  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(input logic m, input logic [15:0] x, input logic [15:0] y, input exp_t ex);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", in_ready, 1);
    if (!in_ready) return;
    mode = m;
    a = x;
    b = y;
    in_valid = 1'b1;
    sb_q.push_back(ex);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end
  initial begin
    exp_t ex;
    int ac;
    logic [15:0] hc;
    logic he;
    logic pv = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !pv) begin
        if (sb_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          ex = sb_q.pop_front();
          ac = acc_q.pop_front();
          chk("c", c, ex.c);
          chk("error", error, ex.e);
          chk("latency", cyc - ac, ex.lat);
        end
        hc = c;
        he = error;
      end else if (out_valid) begin
        chk("c_hold", c, hc);
        chk("error_hold", error, he);
        chk("in_ready_busy", in_ready, 0);
      end
      pv = out_valid;
    end
  end
  initial begin
    logic [15:0] x, y;
    logic m;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_c", c, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    issue(0, 16'h0064, 16'h0007, mk(16'h020E, 0, 9));
    issue(0, 16'h00F9, 16'h0002, mk(16'hFFFD, 0, 9));
    issue(0, 16'h0080, 16'h00FF, mk(16'h007F, 1, 9));
    issue(0, 16'h0005, 16'h0000, mk(16'h007F, 1, 0));
    issue(0, 16'h0080, 16'h0001, mk(16'h0080, 0, 9));
    issue(1, 16'h4200, 16'h4000, mk(16'h3E00, 0, LAT_FP));
    issue(1, 16'h3C00, 16'h4200, mk(16'h3555, 0, LAT_FP));
    issue(1, 16'h7800, 16'h0400, mk(16'h7C00, 1, LAT_FP));
    issue(1, 16'h0400, 16'h7800, mk(16'h0000, 1, LAT_FP));
    issue(1, 16'h3C00, 16'h8000, mk(16'hFC00, 1, 0));
    issue(1, 16'h0000, 16'hC000, mk(16'h8000, 0, 0));
    // Backpressure: result held in DONE while in_valid pulses must be ignored
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    hold = 1'b1;
    issue(0, 16'h0064, 16'h0007, mk(16'h020E, 0, 9));
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    repeat (5) begin
      in_valid = 1'b1;
      mode = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    hold = 1'b0;
    issue(1, 16'h4200, 16'h4000, mk(16'h3E00, 0, LAT_FP));
    // Reset in the middle of an fp division drops the operation
    issue(1, 16'h3C00, 16'h4200, mk(16'h3555, 0, LAT_FP));
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_error", error, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    issue(0, 16'h0064, 16'h0007, mk(16'h020E, 0, 9));
    repeat (150) begin
      m = 1'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        if (m) y[14:10] = 5'h0;
        else y[7:0] = 8'h0;
      end
      if (m && $urandom_range(0, 9) == 0) x[14:10] = 5'h0;
      if (m && $urandom_range(0, 3) != 0) y[14:10] = 5'(x[14:10] + 5'($urandom_range(0, 6)) - 5'd3);
      issue(m, x, y, model(m, x, y));
    end
    n = 0;
    while (sb_q.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
